// File: rtl/sha256_padder_if.sv
// Message-word stream in, padded 512-bit block stream out.
// The padder side uses the slave modport. The producer/consumer side uses the master modport.
interface sha256_padder_if;
    logic         m_valid;
    logic         m_ready;
    logic [31:0]  m_data;
    logic         m_last;
    logic [1:0]   m_last_sz;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_last;

    modport slave (
        input  m_valid, m_data, m_last, m_last_sz, blk_ready,
        output m_ready, blk_valid, blk_data, blk_last
    );

    modport master (
        output m_valid, m_data, m_last, m_last_sz, blk_ready,
        input  m_ready, blk_valid, blk_data, blk_last
    );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder.
// Packs big-endian 32-bit words into 512-bit blocks and appends 0x80, a zero fill
// and the 64-bit message bit length. An extra block is added when the length
// does not fit in the block that holds the last word.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// COLLECT  | accepting message words into the block buffer
// SEND     | offering a non-final block; may be followed by PADBLK
// PADBLK   | building the extra padding block (zeros, opt. 0x80, length)
// SENDLAST | offering the final block of the message
module sha256_padder #(
    parameter int LEN_W = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    sha256_padder_if.slave     bus
);

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        SEND     = 2'd1,
        PADBLK   = 2'd2,
        SENDLAST = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_run;
    logic [3:0]         r_idx;
    logic [LEN_W-1:0]   r_len;
    logic [511:0]       r_blk;
    logic               r_pend;
    logic               r_pend80;

    logic               w_m_ready;
    logic               w_blk_valid;
    logic               w_blk_last;
    logic               w_acc;
    logic [2:0]         w_nbytes;
    logic [6:0]         w_pos;
    logic               w_fits;
    logic [LEN_W:0]     w_len_add;
    logic [LEN_W-1:0]   w_len_sat;
    logic [63:0]        w_len64;
    logic [63:0]        w_rlen64;
    logic [31:0]        w_last_word;
    logic [511:0]       w_blk_col;
    logic [511:0]       w_blk_pad;

    assign w_acc = bus.m_valid && w_m_ready;

    // A last word with m_last_sz = 0 carries all four bytes.
    assign w_nbytes = (bus.m_last && (bus.m_last_sz != 2'd0)) ? {1'b0, bus.m_last_sz} : 3'd4;

    // Byte offset of the 0x80 marker inside the block (64 = it spills into the next block)
    assign w_pos  = {1'b0, r_idx, 2'b00} + {4'b0000, w_nbytes};
    assign w_fits = (w_pos <= 7'd55);

    assign w_len_add = {1'b0, r_len} + (LEN_W+1)'({w_nbytes, 3'b000});
    assign w_len_sat = w_len_add[LEN_W] ? {LEN_W{1'b1}} : w_len_add[LEN_W-1:0];
    assign w_len64   = 64'(w_len_sat);
    assign w_rlen64  = 64'(r_len);

    // Trim the unused low bytes of the last word and place the 0x80 marker.
    always_comb begin
        case (w_nbytes)
            3'd1:    w_last_word = {bus.m_data[31:24], 8'h80, 16'h0000};
            3'd2:    w_last_word = {bus.m_data[31:16], 8'h80, 8'h00};
            3'd3:    w_last_word = {bus.m_data[31:8], 8'h80};
            default: w_last_word = bus.m_data;
        endcase
    end

    // Next buffer image for an accepted word. On the last word, zero the tail and
    // append the length when it fits.
    always_comb begin
        w_blk_col = r_blk;
        for (int w = 0; w < 16; w++) begin
            if (4'(w) == r_idx) begin
                w_blk_col[511-32*w -: 32] = bus.m_last ? w_last_word : bus.m_data;
            end else if (bus.m_last && (4'(w) > r_idx)) begin
                w_blk_col[511-32*w -: 32] =
                    ((w_nbytes == 3'd4) && (4'(w) == r_idx + 4'd1)) ? 32'h8000_0000 : 32'h0000_0000;
            end
        end
        if (bus.m_last && w_fits) begin
            w_blk_col[63:0] = w_len64;
        end
    end

    // Extra block: zeros, 0x80 leading only if the last block was completely full of data.
    always_comb begin
        w_blk_pad = '0;
        if (r_pend80) begin
            w_blk_pad[511:480] = 32'h8000_0000;
        end
        w_blk_pad[63:0] = w_rlen64;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COLLECT: begin
                if (w_acc) begin
                    if (bus.m_last) begin
                        w_state_nxt = w_fits ? SENDLAST : SEND;
                    end else if (r_idx == 4'd15) begin
                        w_state_nxt = SEND;
                    end
                end
            end
            SEND: begin
                if (bus.blk_ready) begin
                    w_state_nxt = r_pend ? PADBLK : COLLECT;
                end
            end
            PADBLK:   w_state_nxt = SENDLAST;
            SENDLAST: begin
                if (bus.blk_ready) begin
                    w_state_nxt = COLLECT;
                end
            end
            default:  w_state_nxt = COLLECT;
        endcase
    end

    // Output decode; r_run keeps m_ready low while in reset.
    always_comb begin
        w_m_ready   = r_run && (r_state == COLLECT);
        w_blk_valid = (r_state == SEND) || (r_state == SENDLAST);
        w_blk_last  = (r_state == SENDLAST);
    end

    assign bus.m_ready   = w_m_ready;
    assign bus.blk_valid = w_blk_valid;
    assign bus.blk_last  = w_blk_last;
    assign bus.blk_data  = r_blk;

    // Datapath: block buffer, word index, bit-length counter, pending-pad flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run    <= 1'b0;
            r_idx    <= 4'd0;
            r_len    <= '0;
            r_blk    <= '0;
            r_pend   <= 1'b0;
            r_pend80 <= 1'b0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                COLLECT: begin
                    if (w_acc) begin
                        r_blk <= w_blk_col;
                        r_len <= w_len_sat;
                        if (bus.m_last) begin
                            r_pend   <= !w_fits;
                            r_pend80 <= (w_pos == 7'd64);
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                PADBLK: begin
                    r_blk    <= w_blk_pad;
                    r_pend   <= 1'b0;
                    r_pend80 <= 1'b0;
                end
                SENDLAST: begin
                    if (bus.blk_ready) begin
                        r_len <= '0;
                        r_idx <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: expected blocks are hand-built from FIPS 180-4 padding.
module tb_sha256_padder;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sha256_padder_if bus ();

    sha256_padder #(.LEN_W(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [511:0] exp_blk;
    logic [511:0] exp_abc;

    task automatic chk_bit(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [511:0] setw(input logic [511:0] b, input int i, input logic [31:0] v);
        logic [511:0] r;
        r = b;
        r[511-32*i -: 32] = v;
        return r;
    endfunction

    // Present one word and hold it until the handshake edge has passed.
    task automatic put_word(input logic [31:0] d, input logic last, input logic [1:0] sz);
        int n;
        n = 0;
        bus.m_valid   = 1'b1;
        bus.m_data    = d;
        bus.m_last    = last;
        bus.m_last_sz = sz;
        while (bus.m_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk_bit("m_ready_wait", bus.m_ready, 1'b1);
        @(posedge clk); #1;
        bus.m_valid = 1'b0;
        bus.m_last  = 1'b0;
    endtask

    // Wait for a block, check it, then take it with a one-cycle blk_ready pulse.
    task automatic get_block(input string tag, input logic [511:0] expd, input logic expl);
        int n;
        n = 0;
        while (bus.blk_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk_bit({tag, "_valid"}, bus.blk_valid, 1'b1);
        chk_blk({tag, "_data"}, bus.blk_data, expd);
        chk_bit({tag, "_last"}, bus.blk_last, expl);
        bus.blk_ready = 1'b1;
        @(posedge clk); #1;
        bus.blk_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.m_valid   = 1'b0;
        bus.m_data    = 32'h0;
        bus.m_last    = 1'b0;
        bus.m_last_sz = 2'd0;
        bus.blk_ready = 1'b0;

        exp_abc = '0;
        exp_abc = setw(exp_abc, 0, 32'h6162_6380);
        exp_abc = setw(exp_abc, 15, 32'h0000_0018);

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk_bit("rst_m_ready", bus.m_ready, 1'b0);
        chk_bit("rst_blk_valid", bus.blk_valid, 1'b0);
        chk_bit("rst_blk_last", bus.blk_last, 1'b0);
        chk_blk("rst_blk_data", bus.blk_data, 512'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk_bit("run_m_ready", bus.m_ready, 1'b1);

        // "abc": single block, valid on the cycle after the word handshake
        put_word(32'h6162_6300, 1'b1, 2'd3);
        chk_bit("abc_latency", bus.blk_valid, 1'b1);
        get_block("abc", exp_abc, 1'b1);
        chk_bit("abc_after_m_ready", bus.m_ready, 1'b1);
        chk_bit("abc_after_valid", bus.blk_valid, 1'b0);

        // 56 bytes: 0x80 lands in word 14, length spills into an extra block
        exp_blk = '0;
        for (int i = 0; i < 14; i++) begin
            put_word(32'hA0B0_C000 + 32'(i), (i == 13), 2'd0);
            exp_blk = setw(exp_blk, i, 32'hA0B0_C000 + 32'(i));
        end
        exp_blk = setw(exp_blk, 14, 32'h8000_0000);
        get_block("m56_b1", exp_blk, 1'b0);
        chk_bit("m56_padblk_valid", bus.blk_valid, 1'b0);
        chk_bit("m56_padblk_m_ready", bus.m_ready, 1'b0);
        exp_blk = setw(512'h0, 15, 32'h0000_01C0);
        get_block("m56_b2", exp_blk, 1'b1);

        // 64 bytes: full data block, then 0x80-led padding block
        exp_blk = '0;
        for (int i = 0; i < 16; i++) begin
            put_word(32'h1234_0000 + 32'(i * 3), (i == 15), 2'd0);
            exp_blk = setw(exp_blk, i, 32'h1234_0000 + 32'(i * 3));
        end
        get_block("m64_b1", exp_blk, 1'b0);
        exp_blk = setw(512'h0, 0, 32'h8000_0000);
        exp_blk = setw(exp_blk, 15, 32'h0000_0200);
        get_block("m64_b2", exp_blk, 1'b1);

        // 55 bytes: 0x80 at byte 55, length still fits in the same block
        exp_blk = '0;
        for (int i = 0; i < 14; i++) begin
            put_word(32'hC000_0000 + 32'(i), (i == 13), 2'd3);
            if (i < 13) exp_blk = setw(exp_blk, i, 32'hC000_0000 + 32'(i));
        end
        exp_blk = setw(exp_blk, 13, 32'hC000_0080);
        exp_blk = setw(exp_blk, 15, 32'h0000_01B8);
        get_block("m55", exp_blk, 1'b1);

        // 57 bytes: 0x80 at byte 57, extra block without a leading 0x80
        exp_blk = '0;
        for (int i = 0; i < 15; i++) begin
            put_word(32'hD000_0000 + 32'(i), (i == 14), 2'd1);
            if (i < 14) exp_blk = setw(exp_blk, i, 32'hD000_0000 + 32'(i));
        end
        exp_blk = setw(exp_blk, 14, 32'hD080_0000);
        get_block("m57_b1", exp_blk, 1'b0);
        exp_blk = setw(512'h0, 15, 32'h0000_01C8);
        get_block("m57_b2", exp_blk, 1'b1);

        // back-to-back: "abc" then an 8-byte message; no length carry-over
        put_word(32'h6162_6300, 1'b1, 2'd3);
        get_block("b2b_abc", exp_abc, 1'b1);
        put_word(32'h0102_0304, 1'b0, 2'd0);
        put_word(32'h0506_0708, 1'b1, 2'd0);
        exp_blk = setw(512'h0, 0, 32'h0102_0304);
        exp_blk = setw(exp_blk, 1, 32'h0506_0708);
        exp_blk = setw(exp_blk, 2, 32'h8000_0000);
        exp_blk = setw(exp_blk, 15, 32'h0000_0040);
        get_block("b2b_m8", exp_blk, 1'b1);

        // 2-byte message
        put_word(32'hBEEF_1234, 1'b1, 2'd2);
        exp_blk = setw(512'h0, 0, 32'hBEEF_8000);
        exp_blk = setw(exp_blk, 15, 32'h0000_0010);
        get_block("m2", exp_blk, 1'b1);

        // consumer stall: block held stable, input blocked
        put_word(32'h6162_6300, 1'b1, 2'd3);
        for (int k = 0; k < 20; k++) begin
            chk_bit("stall_valid", bus.blk_valid, 1'b1);
            chk_blk("stall_data", bus.blk_data, exp_abc);
            chk_bit("stall_m_ready", bus.m_ready, 1'b0);
            @(posedge clk); #1;
        end
        get_block("stall_abc", exp_abc, 1'b1);
        chk_bit("stall_rel_valid", bus.blk_valid, 1'b0);
        chk_bit("stall_rel_m_ready", bus.m_ready, 1'b1);

        // async reset after 7 words aborts the message
        for (int i = 0; i < 7; i++) begin
            put_word(32'hFFFF_0000 + 32'(i), 1'b0, 2'd0);
        end
        reset_n = 1'b0;
        #1;
        chk_bit("mid_rst_m_ready", bus.m_ready, 1'b0);
        chk_bit("mid_rst_blk_valid", bus.blk_valid, 1'b0);
        chk_blk("mid_rst_blk_data", bus.blk_data, 512'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        put_word(32'h6162_6300, 1'b1, 2'd3);
        get_block("post_rst_abc", exp_abc, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
